tiny_core_p: RTL and testbench
==============================

// Module: tiny_core_p
// PURPOSE
//  Parametrised multi-cycle accumulator CPU core; next generation of the tiny8 core, generalised in data width, address width and register count.
//  Control FSM and datapath are merged in one module. Adds a register file, carry/zero flags, two-word instructions, conditional branches and halt.
//  Sits between the testbench/SoC top and a single-port word memory with a read/write/resp handshake.
// PARAMETERS
//  WIDTH     8      data/instruction word width in bits (>=8)
//  AW        8      address width; PC and mem_address are AW bits, word-addressed
//  NREGS     4      general registers R0..R(NREGS-1), power of 2, <=2^(WIDTH-4)
//  RESET_PC  0      PC value loaded on reset
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous active-high reset
//  mem_resp     in   1      memory completed current read/write this cycle
//  mem_rdata    in   WIDTH  read data, valid when mem_resp=1 during a read
//  mem_read     out  1      read request
//  mem_write    out  1      write request
//  mem_address  out  AW     request address
//  mem_wdata    out  WIDTH  write data (=ACC during a write)
//  halted       out  1      core executed HLT and is stopped
//  dbg_acc      out  WIDTH  current accumulator, for verification
// BEHAVIOUR
//  Reset: PC=RESET_PC, ACC=0, all R=0, C=0, Z=0, state FETCH; all outputs 0 (mem_address=0 until FETCH drives PC). Async: takes effect mid-transaction, request dropped immediately.
//  Instr word: op=[WIDTH-1:WIDTH-4], r=[WIDTH-5 -: log2(NREGS)]; other bits ignored.
//  Opcodes: 0 NOP | 1 LDA ACC=R[r] | 2 STA R[r]=ACC | 3 ADD ACC=ACC+R[r], C=carry-out | 4 SUB ACC=ACC-R[r], C=1 iff ACC>=R[r] (unsigned)
//   5 AND ACC&=R[r] | 6 NOT ACC=~ACC | 7 LD ACC=M[a] | 8 ST M[a]=ACC | 9 JMP PC=a | A BRZ if Z PC=a | B BRC if C PC=a
//   C LDI ACC=w | F HLT | D,E execute as NOP. a/w = next word at PC+1; arithmetic mod 2^WIDTH.
//  Z updated (=new ACC==0) on every ACC write (1,3,4,5,6,7,C); C updated only by ADD/SUB; STA/ST/branches leave flags.
//  Taken branch operand a: low AW bits of the word; LD/ST use the same.
//  FSM states:
//   FETCH: mem_read=1, addr=PC; on mem_resp latch IR, PC+=1 -> DECODE.
//   DECODE: 1-word ops execute here -> FETCH; ops 7-C -> OPND; F -> HALT.
//   OPND: mem_read=1, addr=PC; on resp PC+=1; LDI/JMP/BRZ/BRC complete -> FETCH; LD/ST latch a -> MEM.
//   MEM: LD: mem_read, addr=a, on resp ACC=rdata; ST: mem_write, addr=a, wdata=ACC; on resp -> FETCH.
//   HALT: halted=1, no requests; exit only by rst.
//  Handshake: request and address/wdata held stable until mem_resp sampled 1; request deasserted the following cycle (next state may re-assert).
//   mem_resp may arrive in the first request cycle; mem_resp while no request is ignored. mem_read and mem_write never both 1.
//  Min latency (resp same cycle): 1-word op 2 cycles, LDI/JMP/Bxx 3, LD/ST 4. Untaken branch still fetches the operand.
//  PC wraps 2^AW-1 -> 0 silently, including mid two-word fetch.
// TESTING
//  LDI 0x05; STA R1; LDI 0xFE; ADD R1 (W=8) -> ACC=0x03, C=1, Z=0; ADD completes 2 cycles after its fetch request.
//  LDI 0x07; STA R2; SUB R2 -> ACC=0, Z=1, C=1; then BRZ 0x40 -> next fetch address 0x40.
//  ST 0x80 with mem_resp delayed 3 cycles -> mem_write held 4 cycles, address 0x80, wdata=ACC stable, then fetch resumes.
//  HLT at 0x10 -> halted=1, no mem_read for 20 cycles; rst pulse -> halted=0, fetch at RESET_PC.
//  Assert rst during LD wait state -> mem_read drops same cycle, ACC=0, restart at RESET_PC.
//  WIDTH=16, AW=12, NREGS=8: LDI 0xFFFF; ADD R7(=1) -> ACC=0, C=1, Z=1; program at 0xFFF wraps fetch to 0x000.

Source files
------------

// File: rtl/tiny_core_p.sv
// Parametrised multi-cycle accumulator core: merged FSM + datapath, register file,
// carry/zero flags, two-word instructions, branches and halt, single-port memory handshake.
module tiny_core_p #(
  parameter int          WIDTH    = 8,
  parameter int          AW       = 8,
  parameter int          NREGS    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [AW-1:0]    mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             halted,
  output logic [WIDTH-1:0] dbg_acc
);

  localparam int          RW     = $clog2(NREGS);
  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_BRZ = 4'hA;
  localparam logic [3:0] OP_BRC = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_MEM,
    S_HALT
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    pc_q;
  logic [WIDTH-1:0] acc_q;
  logic             c_q;
  logic             z_q;
  logic [3:0]       op_q;
  logic [RW-1:0]    r_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             mem_read_q;
  logic             mem_write_q;
  logic [AW-1:0]    mem_address_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             halted_q;

  logic [WIDTH-1:0] reg_val;
  logic [WIDTH:0]   add_full;
  logic [AW-1:0]    pc_inc;
  logic [AW-1:0]    opnd_a;
  logic [AW-1:0]    opnd_next_pc_d;
  logic [WIDTH-1:0] alu_acc_d;
  logic             alu_we_d;
  logic             alu_c_d;
  logic             alu_c_we_d;

  always_comb begin
    reg_val        = regs_q[r_q];
    add_full       = {1'b0, acc_q} + {1'b0, reg_val};
    pc_inc         = pc_q + AW'(1);
    opnd_a         = AW'(mem_rdata);
    opnd_next_pc_d = pc_inc;
    if ((op_q == OP_JMP) || (op_q == OP_BRZ && z_q) || (op_q == OP_BRC && c_q))
      opnd_next_pc_d = opnd_a;

    alu_acc_d  = acc_q;
    alu_we_d   = 1'b0;
    alu_c_d    = c_q;
    alu_c_we_d = 1'b0;
    case (op_q)
      OP_LDA: begin alu_acc_d = reg_val; alu_we_d = 1'b1; end
      OP_ADD: begin
        alu_acc_d  = add_full[WIDTH-1:0];
        alu_c_d    = add_full[WIDTH];
        alu_we_d   = 1'b1;
        alu_c_we_d = 1'b1;
      end
      OP_SUB: begin
        alu_acc_d  = acc_q - reg_val;
        alu_c_d    = (acc_q >= reg_val);
        alu_we_d   = 1'b1;
        alu_c_we_d = 1'b1;
      end
      OP_AND: begin alu_acc_d = acc_q & reg_val; alu_we_d = 1'b1; end
      OP_NOT: begin alu_acc_d = ~acc_q; alu_we_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RST_PC;
      acc_q         <= '0;
      c_q           <= 1'b0;
      z_q           <= 1'b0;
      op_q          <= '0;
      r_q           <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // Only the first cycle after reset arrives here with no request up.
          if (!mem_read_q) begin
            mem_read_q    <= 1'b1;
            mem_address_q <= pc_q;
          end else if (mem_resp) begin
            op_q       <= mem_rdata[WIDTH-1 -: 4];
            r_q        <= mem_rdata[WIDTH-5 -: RW];
            pc_q       <= pc_inc;
            mem_read_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op_q)
            OP_LD, OP_ST, OP_JMP, OP_BRZ, OP_BRC, OP_LDI: begin
              mem_read_q    <= 1'b1;
              mem_address_q <= pc_q;
              state_q       <= S_OPND;
            end
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              if (alu_we_d) begin
                acc_q <= alu_acc_d;
                z_q   <= (alu_acc_d == '0);
              end
              if (alu_c_we_d) c_q <= alu_c_d;
              if (op_q == OP_STA) regs_q[r_q] <= acc_q;
              mem_read_q    <= 1'b1;
              mem_address_q <= pc_q;
              state_q       <= S_FETCH;
            end
          endcase
        end
        S_OPND: begin
          if (mem_resp) begin
            if (op_q == OP_LD || op_q == OP_ST) begin
              pc_q          <= pc_inc;
              mem_address_q <= opnd_a;
              mem_read_q    <= (op_q == OP_LD);
              mem_write_q   <= (op_q == OP_ST);
              mem_wdata_q   <= (op_q == OP_ST) ? acc_q : '0;
              state_q       <= S_MEM;
            end else begin
              if (op_q == OP_LDI) begin
                acc_q <= mem_rdata;
                z_q   <= (mem_rdata == '0);
              end
              pc_q          <= opnd_next_pc_d;
              mem_address_q <= opnd_next_pc_d;
              state_q       <= S_FETCH;
            end
          end
        end
        S_MEM: begin
          if (mem_resp) begin
            if (mem_read_q) begin
              acc_q <= mem_rdata;
              z_q   <= (mem_rdata == '0);
            end
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b1;
            mem_address_q <= pc_q;
            state_q       <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign halted      = halted_q;
  assign dbg_acc     = acc_q;

endmodule

// File: tb/tb_tiny_core_p.sv
// Bench for tiny_core_p: an 8-bit and a 16-bit instance share one memory model whose
// responses are checked against a queue of expected bus transactions.
module tb_tiny_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, rst16, sel16;
  logic        resp;
  logic [15:0] rdata;

  logic        rd8, wr8, halt8;
  logic [7:0]  addr8, wdata8, acc8;
  logic        rd16, wr16, halt16;
  logic [11:0] addr16;
  logic [15:0] wdata16, acc16;

  logic resp8, resp16;
  assign resp8  = resp & ~sel16;
  assign resp16 = resp & sel16;

  tiny_core_p #(.WIDTH(8), .AW(8), .NREGS(4), .RESET_PC(0)) u8 (
    .clk(clk), .rst(rst8), .mem_resp(resp8), .mem_rdata(rdata[7:0]),
    .mem_read(rd8), .mem_write(wr8), .mem_address(addr8), .mem_wdata(wdata8),
    .halted(halt8), .dbg_acc(acc8));

  tiny_core_p #(.WIDTH(16), .AW(12), .NREGS(8), .RESET_PC(12'hFFC)) u16 (
    .clk(clk), .rst(rst16), .mem_resp(resp16), .mem_rdata(rdata),
    .mem_read(rd16), .mem_write(wr16), .mem_address(addr16), .mem_wdata(wdata16),
    .halted(halt16), .dbg_acc(acc16));

  logic        a_read, a_write, a_halted, a_rst;
  logic [11:0] a_addr;
  logic [15:0] a_wdata, a_acc;
  always_comb begin
    if (sel16) begin
      a_read = rd16; a_write = wr16; a_halted = halt16; a_rst = rst16;
      a_addr = addr16; a_wdata = wdata16; a_acc = acc16;
    end else begin
      a_read = rd8; a_write = wr8; a_halted = halt8; a_rst = rst8;
      a_addr = {4'h0, addr8}; a_wdata = {8'h00, wdata8}; a_acc = {8'h00, acc8};
    end
  end

  typedef struct {
    bit wr;
    int addr;
    int data;
    int gap;
  } txn_t;

  txn_t        sb[$];
  txn_t        t_pop;
  logic [15:0] mem [4096];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_cyc = 0, wait_cnt = 0, delay = 0, stall_addr = -1;
  int wr_total = 0, wd_chg = 0, both_cnt = 0;
  logic [15:0] wd_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic exp_rd(input int addr, input int gap);
    txn_t t;
    t.wr = 1'b0; t.addr = addr; t.data = 0; t.gap = gap;
    sb.push_back(t);
  endtask

  task automatic exp_wr(input int addr, input int data, input int gap);
    txn_t t;
    t.wr = 1'b1; t.addr = addr; t.data = data; t.gap = gap;
    sb.push_back(t);
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: answers after `delay` waiting cycles, never for stall_addr.
  always @(negedge clk) begin
    resp = 1'b0;
    if (a_read && a_write) both_cnt++;
    if (a_write) begin
      wr_total++;
      if (wr_total > 1 && a_wdata != wd_prev) wd_chg++;
      wd_prev = a_wdata;
    end
    if ((a_read || a_write) && !a_rst) begin
      if ({20'h0, a_addr} != stall_addr && wait_cnt >= delay) begin
        resp = 1'b1;
        if (a_read) rdata = mem[a_addr];
        else mem[a_addr] = a_wdata;
        $display("[TB] cyc %0d %s addr=0x%03h data=0x%04h", cyc, a_write ? "WR" : "RD",
                 a_addr, a_write ? a_wdata : rdata);
        if (sb.size() == 0) chk("sb_extra", 1, 0);
        else begin
          t_pop = sb.pop_front();
          chk("txn_wr", {31'b0, a_write}, {31'b0, t_pop.wr});
          chk("txn_addr", {20'h0, a_addr}, t_pop.addr);
          if (t_pop.wr) chk("txn_wdata", {16'h0, a_wdata}, t_pop.data);
          if (t_pop.gap >= 0) chk("txn_gap", cyc - last_cyc, t_pop.gap);
        end
        last_cyc = cyc;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic start(input bit s16, input int dly);
    rst8 = 1'b1; rst16 = 1'b1; sel16 = s16;
    delay = dly; stall_addr = -1;
    sb.delete();
    wr_total = 0; wd_chg = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic go();
    @(negedge clk);
    if (sel16) rst16 = 1'b0;
    else rst8 = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_halted) break;
    end
    chk("halt_reached", {31'b0, a_halted}, 1);
  endtask

  task automatic wait_stall(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_read && a_addr == 12'h090) break;
    end
    chk("stall_seen", {31'b0, a_read && a_addr == 12'h090}, 1);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_read"}, {31'b0, a_read}, 0);
    chk({tag, "_write"}, {31'b0, a_write}, 0);
    chk({tag, "_addr"}, {20'h0, a_addr}, 0);
    chk({tag, "_halted"}, {31'b0, a_halted}, 0);
    chk({tag, "_acc"}, {16'h0, a_acc}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt;
    resp = 1'b0; rdata = '0; rst8 = 1'b1; rst16 = 1'b1; sel16 = 1'b0;

    // LDI 5; STA R1; LDI FE; ADD R1 -> 03, C=1, Z=0 (BRZ falls through, BRC taken)
    start(0, 0);
    reset_outputs_zero("rst8");
    mem[0] = 16'hC0; mem[1] = 16'h05; mem[2] = 16'h24; mem[3] = 16'hC0; mem[4] = 16'hFE;
    mem[5] = 16'h34; mem[6] = 16'hA0; mem[7] = 16'h30; mem[8] = 16'hB0; mem[9] = 16'h20;
    mem[32] = 16'hF0;
    exp_rd(0, -1); exp_rd(1, 2); exp_rd(2, 1); exp_rd(3, 2); exp_rd(4, 2); exp_rd(5, 1);
    exp_rd(6, 2); exp_rd(7, 2); exp_rd(8, 1); exp_rd(9, 2); exp_rd(32, 1);
    go();
    wait_halt(100);
    chk("t1_acc", {16'h0, a_acc}, 32'h03);
    chk("t1_sb_left", sb.size(), 0);

    // LDI 7; STA R2; SUB R2 -> 0, Z=1; BRZ 0x40 taken
    start(0, 0);
    mem[0] = 16'hC0; mem[1] = 16'h07; mem[2] = 16'h28; mem[3] = 16'h48; mem[4] = 16'hA0;
    mem[5] = 16'h40; mem[64] = 16'hF0;
    exp_rd(0, -1); exp_rd(1, 2); exp_rd(2, 1); exp_rd(3, 2); exp_rd(4, 2); exp_rd(5, 2);
    exp_rd(64, 1);
    go();
    wait_halt(100);
    chk("t2_acc", {16'h0, a_acc}, 0);
    chk("t2_sb_left", sb.size(), 0);

    // ST 0x80 and LD back with every response delayed 3 cycles
    start(0, 3);
    mem[0] = 16'hC0; mem[1] = 16'h5A; mem[2] = 16'h80; mem[3] = 16'h80; mem[4] = 16'hC0;
    mem[5] = 16'h00; mem[6] = 16'h70; mem[7] = 16'h80; mem[8] = 16'hF0;
    exp_rd(0, -1); exp_rd(1, 5); exp_rd(2, 4); exp_rd(3, 5); exp_wr(128, 32'h5A, 4);
    exp_rd(4, 4); exp_rd(5, 5); exp_rd(6, 4); exp_rd(7, 5); exp_rd(128, 4); exp_rd(8, 4);
    go();
    wait_halt(200);
    chk("t3_acc", {16'h0, a_acc}, 32'h5A);
    chk("t3_write_cycles", wr_total, 4);
    chk("t3_wdata_changes", wd_chg, 0);
    chk("t3_sb_left", sb.size(), 0);

    // JMP 0x10; HLT, stays quiet, restarts from reset PC after rst pulse
    start(0, 0);
    mem[0] = 16'h90; mem[1] = 16'h10; mem[16] = 16'hF0;
    exp_rd(0, -1); exp_rd(1, 2); exp_rd(16, 1);
    go();
    wait_halt(100);
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_read) rd_cnt++;
    end
    chk("t4_halt_reads", rd_cnt, 0);
    chk("t4_halted", {31'b0, a_halted}, 1);
    exp_rd(0, -1); exp_rd(1, 2); exp_rd(16, 1);
    rst8 = 1'b1;
    #1;
    chk("t4_rst_halted", {31'b0, a_halted}, 0);
    go();
    wait_halt(100);
    chk("t4_sb_left", sb.size(), 0);

    // Asynchronous reset while LD waits for memory
    start(0, 0);
    stall_addr = 32'h90;
    mem[0] = 16'hC0; mem[1] = 16'h33; mem[2] = 16'h70; mem[3] = 16'h90;
    exp_rd(0, -1); exp_rd(1, 2); exp_rd(2, 1); exp_rd(3, 2);
    go();
    wait_stall(50);
    repeat (3) @(negedge clk);
    chk("t5_acc_before", {16'h0, a_acc}, 32'h33);
    chk("t5_sb_left", sb.size(), 0);
    @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("t5_rst_read", {31'b0, a_read}, 0);
    chk("t5_rst_acc", {16'h0, a_acc}, 0);
    exp_rd(0, -1); exp_rd(1, 2); exp_rd(2, 1); exp_rd(3, 2);
    go();
    wait_stall(50);
    chk("t5_restart_sb_left", sb.size(), 0);

    // 16-bit instance: LDI FFFF wraps mid two-word fetch; ADD R7(=1) -> 0, C=1, Z=1
    start(1, 0);
    reset_outputs_zero("rst16");
    mem[12'hFFC] = 16'hC000; mem[12'hFFD] = 16'h0001; mem[12'hFFE] = 16'h2E00;
    mem[12'hFFF] = 16'hC000; mem[12'h000] = 16'hFFFF; mem[12'h001] = 16'h3E00;
    mem[12'h002] = 16'hA000; mem[12'h003] = 16'h0010; mem[12'h010] = 16'hB000;
    mem[12'h011] = 16'h0020; mem[12'h020] = 16'hF000;
    exp_rd(12'hFFC, -1); exp_rd(12'hFFD, 2); exp_rd(12'hFFE, 1); exp_rd(12'hFFF, 2);
    exp_rd(12'h000, 2); exp_rd(12'h001, 1); exp_rd(12'h002, 2); exp_rd(12'h003, 2);
    exp_rd(12'h010, 1); exp_rd(12'h011, 2); exp_rd(12'h020, 1);
    go();
    wait_halt(100);
    chk("t6_acc", {16'h0, a_acc}, 0);
    chk("t6_sb_left", sb.size(), 0);

    chk("read_write_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
